// File: rtl/imm_gen_pipe.sv
// Decodes and extends the RISC-V immediate from instr[31:7]. The result and its tag appear one cycle after accept.
// Output register plus a one-entry skid; ready_in is registered and drops only when both are full.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 8,
  parameter bit CSR_EN = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_in,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [24:0]      instr_in,
  input  logic [2:0]       imm_type_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] tag_out
);

  typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
  } entry_t;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  // instr_in[k] carries instruction bit k+7
  logic [11:0] i_imm;
  logic [11:0] s_imm;
  logic [12:0] b_imm;
  logic [31:0] u_imm;
  logic [20:0] j_imm;
  logic [4:0]  zimm;

  assign i_imm = instr_in[24:13];
  assign s_imm = {instr_in[24:18], instr_in[4:0]};
  assign b_imm = {instr_in[24], instr_in[0], instr_in[23:18], instr_in[4:1], 1'b0};
  assign u_imm = {instr_in[24:5], 12'h000};
  assign j_imm = {instr_in[24], instr_in[12:5], instr_in[13], instr_in[23:14], 1'b0};
  assign zimm  = instr_in[12:8];

  logic [XLEN-1:0] imm_d;

  always_comb begin
    imm_d = '0;
    case (imm_type_in)
      3'b001, 3'b111: imm_d = XLEN'($signed(i_imm));
      3'b010:         imm_d = XLEN'($signed(s_imm));
      3'b011:         imm_d = XLEN'($signed(b_imm));
      3'b100:         imm_d = XLEN'($signed(u_imm));
      3'b101:         imm_d = XLEN'($signed(j_imm));
      3'b110:         imm_d = CSR_EN ? XLEN'(zimm) : XLEN'($signed(i_imm));
      default:        imm_d = '0;
    endcase
  end

  entry_t new_d;
  assign new_d = {imm_d, tag_in};

  state_t state_q;
  entry_t out_q;
  entry_t skid_q;
  logic   valid_q;
  logic   ready_q;
  logic   accept;
  logic   consume;

  assign accept  = valid_in & ready_q;
  assign consume = valid_q & ready_out;

  // valid_q/ready_q are kept as registered copies of the state so outputs never see decode logic
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (flush_in) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_q   <= new_d;
            state_q <= ST_BUSY;
            valid_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (accept && consume) begin
            out_q <= new_d;
          end else if (accept) begin
            skid_q  <= new_d;
            state_q <= ST_FULL;
            ready_q <= 1'b0;
          end else if (consume) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (consume) begin
            out_q   <= skid_q;
            state_q <= ST_BUSY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_in  = ready_q;
  assign valid_out = valid_q;
  assign imm_out   = out_q.imm;
  assign tag_out   = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: two instances (XLEN=32 with CSR zimm, XLEN=64 without) share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        vin;
  logic [24:0] instr;
  logic [2:0]  typ;
  logic [7:0]  tag;
  logic        rout;
  logic        rin32, rin64, vout32, vout64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [7:0]  tag32, tag64;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CSR_EN(1'b1)) dut32 (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(vin), .ready_in(rin32),
    .instr_in(instr), .imm_type_in(typ), .tag_in(tag), .valid_out(vout32), .ready_out(rout),
    .imm_out(imm32), .tag_out(tag32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CSR_EN(1'b0)) dut64 (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(vin), .ready_in(rin64),
    .instr_in(instr), .imm_type_in(typ), .tag_in(tag), .valid_out(vout64), .ready_out(rout),
    .imm_out(imm64), .tag_out(tag64));

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  t;
    logic [7:0]  tg;
  } ent_t;

  // Reference decode from the full 32-bit instruction using signed arithmetic shifts
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] t, input bit csr_en);
    longint s, a12, a20, a25, a31;
    s   = longint'($signed(ins));
    a12 = s >>> 12;
    a20 = s >>> 20;
    a25 = s >>> 25;
    a31 = s >>> 31;
    case (t)
      3'd1, 3'd7: return a20;
      3'd2: return (a25 << 5) | 64'(ins[11:7]);
      3'd3: return (a31 << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      3'd4: return a12 << 12;
      3'd5: return (a31 << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
      3'd6: return csr_en ? 64'(ins[19:15]) : a20;
      default: return 64'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [2:0] t, input logic [7:0] tg);
    vin   = v;
    instr = w[31:7];
    typ   = t;
    tag   = tg;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; rout = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 8'h0);
    #12;
    n_cmp++; if (vout32 !== 1'b0) begin n_err++; $display("FAIL reset_valid32: got %b want 0", vout32); end
    n_cmp++; if (rin32 !== 1'b1) begin n_err++; $display("FAIL reset_ready32: got %b want 1", rin32); end
    n_cmp++; if (imm32 !== 32'h0) begin n_err++; $display("FAIL reset_imm32: got %h want 0", imm32); end
    n_cmp++; if (tag32 !== 8'h0) begin n_err++; $display("FAIL reset_tag32: got %h want 0", tag32); end
    n_cmp++; if (imm64 !== 64'h0 || vout64 !== 1'b0) begin n_err++; $display("FAIL reset_64: got imm %h vld %b want 0/0", imm64, vout64); end
    #6;
    rst_n = 1'b1;
    tick();
  endtask

  localparam int NV = 10;
  localparam logic [31:0] V_INS [NV] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h123450B7, 32'h0010006F,
                                          32'h801F8073, 32'h800000B7, 32'h7FF00093, 32'hFFFFFF93, 32'hFFF00093};
  localparam logic [2:0]  V_TYP [NV] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd4, 3'd1, 3'd0, 3'd7};
  localparam logic [31:0] V_E32 [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'h00000800,
                                          32'h0000001F, 32'h80000000, 32'h000007FF, 32'h00000000, 32'hFFFFFFFF};
  localparam logic [63:0] V_E64 [NV] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                                          64'h0000000012345000, 64'h0000000000000800, 64'hFFFFFFFFFFFFF801,
                                          64'hFFFFFFFF80000000, 64'h00000000000007FF, 64'h0, 64'hFFFFFFFFFFFFFFFF};

  task automatic test_decode();
    logic [31:0] w;
    rout = 1'b1;
    for (int i = 0; i < NV; i++) begin
      w = V_INS[i];
      drive(1'b1, w, V_TYP[i], 8'(i + 1));
      tick();
      drive(1'b0, 32'h0, 3'd0, 8'h0);
      n_cmp++; if (vout32 !== 1'b1) begin n_err++; $display("FAIL dec_valid[%0d]: got %b want 1", i, vout32); end
      n_cmp++; if (imm32 !== V_E32[i]) begin n_err++; $display("FAIL dec_imm32[%0d]: got %h want %h", i, imm32, V_E32[i]); end
      n_cmp++; if (imm64 !== V_E64[i]) begin n_err++; $display("FAIL dec_imm64[%0d]: got %h want %h", i, imm64, V_E64[i]); end
      n_cmp++; if (tag32 !== 8'(i + 1)) begin n_err++; $display("FAIL dec_tag[%0d]: got %h want %h", i, tag32, 8'(i + 1)); end
      tick();
      n_cmp++; if (vout32 !== 1'b0) begin n_err++; $display("FAIL dec_drain[%0d]: got %b want 0", i, vout32); end
    end
  endtask

  task automatic test_back_to_back();
    int nt = 1;
    int cyc;
    logic [7:0]  got[$];
    logic [31:0] hold_imm;
    logic [7:0]  hold_tag;
    logic acc, con;
    hold_imm = '0; hold_tag = '0;
    for (cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
      rout = !(cyc >= 3 && cyc <= 5);
      drive(nt <= 6, $urandom, 3'($urandom_range(0, 7)), 8'(nt));
      if (cyc == 3) begin
        n_cmp++; if (rin32 !== 1'b1) begin n_err++; $display("FAIL bp_ready_stall_start: got %b want 1", rin32); end
        hold_imm = imm32; hold_tag = tag32;
      end
      if (cyc >= 4 && cyc <= 6) begin
        n_cmp++; if (imm32 !== hold_imm || tag32 !== hold_tag) begin
          n_err++; $display("FAIL bp_hold[%0d]: got %h/%h want %h/%h", cyc, imm32, tag32, hold_imm, hold_tag);
        end
      end
      acc = vin & rin32;
      con = vout32 & rout;
      if (con) got.push_back(tag32);
      if (acc) nt++;
      tick();
      if (cyc == 3) begin
        n_cmp++; if (rin32 !== 1'b0) begin n_err++; $display("FAIL bp_ready_fall: got %b want 0", rin32); end
      end
    end
    drive(1'b0, 32'h0, 3'd0, 8'h0);
    rout = 1'b1;
    n_cmp++; if (got.size() != 6) begin n_err++; $display("FAIL bp_count: got %0d want 6", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++; if (got[i] !== 8'(i + 1)) begin n_err++; $display("FAIL bp_seq[%0d]: got %0d want %0d", i, got[i], i + 1); end
    end
    tick();
    n_cmp++; if (vout32 !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", vout32); end
  endtask

  task automatic fill_full();
    rout = 1'b0;
    drive(1'b1, 32'h00100093, 3'd1, 8'h11);
    tick();
    drive(1'b1, 32'h00200093, 3'd1, 8'h22);
    tick();
    drive(1'b0, 32'h0, 3'd0, 8'h0);
  endtask

  task automatic test_flush();
    fill_full();
    n_cmp++; if (rin32 !== 1'b0) begin n_err++; $display("FAIL flush_full: ready got %b want 0", rin32); end
    flush = 1'b1;
    drive(1'b1, 32'h12345037, 3'd4, 8'hAA);
    tick();
    n_cmp++; if (vout32 !== 1'b0 || vout64 !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b/%b want 0", vout32, vout64); end
    n_cmp++; if (rin32 !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", rin32); end
    drive(1'b1, 32'h12345037, 3'd4, 8'hBB);
    tick();
    n_cmp++; if (vout32 !== 1'b0) begin n_err++; $display("FAIL flush_beats_accept: got %b want 0", vout32); end
    flush = 1'b0;
    rout = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 8'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (vout32 !== 1'b0) begin n_err++; $display("FAIL flush_no_ghost[%0d]: got %b tag %h want 0", i, vout32, tag32); end
    end
  endtask

  task automatic test_reset_midflight();
    fill_full();
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (vout32 !== 1'b0 || vout64 !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b/%b want 0", vout32, vout64); end
    n_cmp++; if (imm32 !== 32'h0 || imm64 !== 64'h0) begin n_err++; $display("FAIL arst_imm: got %h/%h want 0", imm32, imm64); end
    n_cmp++; if (rin32 !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %b want 1", rin32); end
    #2;
    rst_n = 1'b1;
    rout = 1'b1;
    tick();
    n_cmp++; if (vout32 !== 1'b0) begin n_err++; $display("FAIL arst_after: got %b want 0", vout32); end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    logic [63:0] exp;
    logic acc, con, fl;
    for (int c = 0; c < 10000; c++) begin
      fl    = ($urandom_range(0, 49) == 0);
      flush = fl;
      rout  = ($urandom_range(0, 9) < 6);
      e.ins = $urandom;
      e.t   = 3'($urandom_range(0, 7));
      e.tg  = 8'($urandom_range(0, 255));
      drive($urandom_range(0, 9) < 7, e.ins, e.t, e.tg);
      acc = vin && (q.size() < 2);
      con = (q.size() > 0) && rout;
      tick();
      if (fl) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      n_cmp++; if (vout32 !== (q.size() > 0) || vout64 !== (q.size() > 0)) begin
        n_err++; $display("FAIL rnd_valid[%0d]: got %b/%b want %b", c, vout32, vout64, q.size() > 0);
      end
      n_cmp++; if (rin32 !== (q.size() < 2) || rin64 !== (q.size() < 2)) begin
        n_err++; $display("FAIL rnd_ready[%0d]: got %b/%b want %b", c, rin32, rin64, q.size() < 2);
      end
      if (q.size() > 0) begin
        exp = ref_imm(q[0].ins, q[0].t, 1'b1);
        n_cmp++; if (imm32 !== exp[31:0] || tag32 !== q[0].tg) begin
          n_err++; $display("FAIL rnd_out32[%0d]: got %h/%h want %h/%h", c, imm32, tag32, exp[31:0], q[0].tg);
        end
        exp = ref_imm(q[0].ins, q[0].t, 1'b0);
        n_cmp++; if (imm64 !== exp || tag64 !== q[0].tg) begin
          n_err++; $display("FAIL rnd_out64[%0d]: got %h/%h want %h/%h", c, imm64, tag64, exp, q[0].tg);
        end
      end
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 8'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
